// File: rtl/matvec_pkg.sv
// Shared types and elaboration helpers for the systolic matrix-vector multiplier.
package matvec_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam int ACC_W_MAX = 48;

  // Bits needed for a counter running 0..n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit acc_w_ok(input int acc_w, input int dw);
    return (acc_w >= 2 * dw) && (acc_w <= ACC_W_MAX);
  endfunction

endpackage

// File: rtl/matvec_pe.sv
// One systolic row: registers A, B and the enable tag, then multiply-accumulates.
// MATVEC_SATURATE_EN selects clamp-at-max instead of wrap-around accumulation.
module matvec_pe
  import matvec_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en_in,
  input  logic [DW-1:0]    a_in,
  input  logic [DW-1:0]    b_in,
  output logic             en_out,
  output logic [DW-1:0]    b_out,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [DW-1:0]    a_r;
  logic [2*DW-1:0]  prod;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;

  always_comb begin
    prod = {{DW{1'b0}}, a_r} * {{DW{1'b0}}, b_out};
    sum  = {1'b0, acc} + {{(ACC_W + 1 - 2 * DW){1'b0}}, prod};
`ifdef MATVEC_SATURATE_EN
    acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    acc_next = sum[ACC_W-1:0];
`endif
    carry = en_out & sum[ACC_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_out  <= '0;
      en_out <= 1'b0;
      acc    <= '0;
    end else begin
      a_r   <= a_in;
      b_out <= b_in;
      if (clr) begin
        en_out <= 1'b0;
        acc    <= '0;
      end else begin
        en_out <= en_in;
        if (en_out) acc <= acc_next;
      end
    end
  end

endmodule

// File: rtl/matvec_systolic.sv
// Systolic C = A x B: FSM, beat/drain counter, per-row A skew lines and PE chain.
// Build with MATVEC_SATURATE_EN for saturating accumulators (wrap-around otherwise).
module matvec_systolic
  import matvec_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DW    = 8,
  parameter int ACC_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*DW-1:0]    a_col,
  input  logic [DW-1:0]         b_elem,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROWS*ACC_W-1:0] c_out,
  output logic                  busy,
  output logic                  ovf
);

  localparam int CW = cnt_w((ROWS > COLS) ? ROWS : COLS);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(COLS - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(ROWS - 1);

  if (!acc_w_ok(ACC_W, DW)) begin : g_bad_acc_w
    $error("matvec_systolic: ACC_W must lie in 2*DW..48");
  end

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            accept, start_ok, pe_clr;
  logic [ROWS-1:0] carry;
  logic            en_link [ROWS+1];
  logic [DW-1:0]   b_link  [ROWS+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    start_ok   = 1'b0;
    unique case (state)
      IDLE: begin
        start_ok = start;
        if (start) begin
          state_next = LOAD;
          cnt_next   = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (cnt == LAST_BEAT) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (cnt == LAST_DRAIN) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        start_ok  = start;
        if (start) begin
          state_next = LOAD;
          cnt_next   = '0;
        end else if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (clr) begin
      state_next = IDLE;
      cnt_next   = '0;
      start_ok   = 1'b0;
    end
  end

  assign accept = in_valid & in_ready;
  assign pe_clr = clr | start_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ovf <= 1'b0;
    else if (pe_clr)   ovf <= 1'b0;
    else if (|carry)   ovf <= 1'b1;
  end

  assign en_link[0] = accept;
  assign b_link[0]  = b_elem;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    logic [DW-1:0] a_feed;

    if (i == 0) begin : g_direct
      assign a_feed = a_col[DW-1:0];
    end else begin : g_skew
      // i-deep delay line; the oldest entry sits in the top DW bits of sr.
      logic [i*DW-1:0]     sr;
      logic [(i+1)*DW-1:0] shifted;
      assign shifted = {sr, a_col[i*DW +: DW]};
      assign a_feed  = shifted[(i+1)*DW-1 -: DW];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= shifted[i*DW-1:0];
      end
    end

    matvec_pe #(.DW(DW), .ACC_W(ACC_W)) u_pe (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (pe_clr),
      .en_in  (en_link[i]),
      .a_in   (a_feed),
      .b_in   (b_link[i]),
      .en_out (en_link[i+1]),
      .b_out  (b_link[i+1]),
      .acc    (c_out[i*ACC_W +: ACC_W]),
      .carry  (carry[i])
    );
  end

endmodule

// File: tb/tb_matvec_systolic.sv
// Directed + randomized bench for matvec_systolic against an arithmetic reference model.
module tb_matvec_systolic;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [ROWS*DW-1:0] a_col = '0;
  logic [DW-1:0]      b_elem = '0;

  logic in_ready, out_valid, busy, ovf;
  logic [ROWS*24-1:0] c_out;
  logic in_ready16, out_valid16, busy16, ovf16;
  logic [ROWS*16-1:0] c_out16;

  logic        s_start = 1'b0, s_valid = 1'b0, s_oready = 1'b0;
  logic [15:0] s_a = '0;
  logic [7:0]  s_b = '0;
  logic        s_ready, s_ovalid, s_busy, s_ovf;
  logic [31:0] s_c;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] A [ROWS][COLS];
  logic [DW-1:0] B [COLS];
  logic [63:0]   exp24 [ROWS];
  logic [63:0]   exp16 [ROWS];
  logic          exp_o24, exp_o16;
  logic [ROWS*24-1:0] last24 = '0;
  logic [ROWS*16-1:0] last16 = '0;

  always #5 clk = ~clk;

  matvec_systolic #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready), .a_col(a_col), .b_elem(b_elem), .out_valid(out_valid),
    .out_ready(out_ready), .c_out(c_out), .busy(busy), .ovf(ovf));

  matvec_systolic #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .in_valid(in_valid),
    .in_ready(in_ready16), .a_col(a_col), .b_elem(b_elem), .out_valid(out_valid16),
    .out_ready(out_ready), .c_out(c_out16), .busy(busy16), .ovf(ovf16));

  matvec_systolic #(.ROWS(2), .COLS(1), .DW(DW), .ACC_W(16)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .clr(clr), .in_valid(s_valid),
    .in_ready(s_ready), .a_col(s_a), .b_elem(s_b), .out_valid(s_ovalid),
    .out_ready(s_oready), .c_out(s_c), .busy(s_busy), .ovf(s_ovf));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic logic [63:0] fold(input logic [63:0] s, input int w);
    logic [63:0] mx;
    mx = (64'd1 << w) - 64'd1;
`ifdef MATVEC_SATURATE_EN
    return (s > mx) ? mx : s;
`else
    return s & mx;
`endif
  endfunction

  // Reference: plain dot products, then reduce to each accumulator width.
  task automatic model();
    exp_o24 = 1'b0;
    exp_o16 = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      logic [63:0] s;
      s = '0;
      for (int j = 0; j < COLS; j++) s += 64'(A[i][j]) * 64'(B[j]);
      exp24[i] = fold(s, 24);
      exp16[i] = fold(s, 16);
      if (s > 64'hFF_FFFF) exp_o24 = 1'b1;
      if (s > 64'hFFFF)    exp_o16 = 1'b1;
    end
  endtask

  task automatic fill(input int kind);
    for (int j = 0; j < COLS; j++) begin
      B[j] = (kind == 0) ? 8'd1 : (kind == 1) ? 8'd255 : 8'($urandom_range(0, 255));
      for (int i = 0; i < ROWS; i++)
        A[i][j] = (kind == 0) ? 8'(i + 1) : (kind == 1) ? 8'd255 : 8'($urandom_range(0, 255));
    end
  endtask

  task automatic check_held();
    for (int i = 0; i < ROWS; i++) begin
      check($sformatf("held24[%0d]", i), 64'(c_out[i*24 +: 24]), 64'(last24[i*24 +: 24]));
      check($sformatf("held16[%0d]", i), 64'(c_out16[i*16 +: 16]), 64'(last16[i*16 +: 16]));
    end
  endtask

  task automatic start_job();
    check_held();
    start = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    check("ready_after_start", 64'(in_ready & in_ready16), 64'd1);
    check("busy_after_start", 64'(busy), 64'd1);
    check("cleared_after_start", 64'((c_out != '0) || (c_out16 != '0)), 64'd0);
    check("ovf_cleared", 64'({ovf, ovf16}), 64'd0);
  endtask

  // mode 0: valid every cycle, 1: alternate, 2: random. noise toggles start.
  task automatic feed(input int n, input int mode, input bit noise);
    int j, cyc;
    bit v, ok;
    j = 0;
    cyc = 0;
    while (j < n && cyc < 200) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      in_valid = v;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v) begin
        for (int i = 0; i < ROWS; i++) a_col[i*DW +: DW] = A[i][j];
        b_elem = B[j];
      end else begin
        a_col = {2{32'($urandom)}};
        b_elem = 8'($urandom);
      end
      ok = v && in_ready;
      @(negedge clk);
      if (ok) j++;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("beats_accepted", 64'(j), 64'(n));
  endtask

  task automatic finish_job(input int mode, input bit noise, input bit release_out);
    int n;
    model();
    feed(COLS, mode, noise);
    in_valid = 1'b1;
    a_col = {2{32'($urandom)}};
    b_elem = 8'hFF;
    check("ready_low_after_last", 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(ROWS));
    check("out_valid16", 64'(out_valid16), 64'd1);
    for (int i = 0; i < ROWS; i++) begin
      check($sformatf("c24[%0d]", i), 64'(c_out[i*24 +: 24]), exp24[i]);
      check($sformatf("c16[%0d]", i), 64'(c_out16[i*16 +: 16]), exp16[i]);
      last24[i*24 +: 24] = exp24[i][23:0];
      last16[i*16 +: 16] = exp16[i][15:0];
    end
    check("ovf24", 64'(ovf), 64'(exp_o24));
    check("ovf16", 64'(ovf16), 64'(exp_o16));
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_after_out_ready", 64'({out_valid, busy}), 64'd0);
    end
  endtask

  initial begin
    #12;
    check("rst_outputs", 64'({in_ready, out_valid, busy, ovf}), 64'd0);
    check("rst_c_out", 64'(c_out != '0), 64'd0);
    check("rst_outputs16", 64'({in_ready16, out_valid16, busy16, ovf16}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // COLS=1 instance: one beat then straight into drain.
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("c1_ready", 64'(s_ready), 64'd1);
    s_valid = 1'b1;
    s_a = {8'd5, 8'd3};
    s_b = 8'd7;
    @(negedge clk);
    check("c1_ready_after_beat", 64'({s_ready, s_busy}), 64'b01);
    begin
      int n;
      n = 0;
      while (!s_ovalid && n < 20) begin @(negedge clk); n++; end
      check("c1_latency", 64'(n), 64'd2);
    end
    s_valid = 1'b0;
    check("c1_row0", 64'(s_c[15:0]), 64'd21);
    check("c1_row1", 64'(s_c[31:16]), 64'd35);
    check("c1_ovf", 64'(s_ovf), 64'd0);

    fill(0); start_job(); finish_job(0, 1'b0, 1'b1);   // baseline
    fill(1); start_job(); finish_job(0, 1'b0, 1'b1);   // max operands / 16-bit overflow
    fill(0); start_job(); finish_job(1, 1'b0, 1'b1);   // alternating stalls

    // Abort after 4 beats; no late accumulates may survive the clear.
    fill(0); start_job(); feed(4, 0, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_state", 64'({busy, in_ready, out_valid, ovf}), 64'd0);
    check("clr_c_out", 64'((c_out != '0) || (c_out16 != '0)), 64'd0);
    repeat (ROWS + 2) @(negedge clk);
    check("clr_no_late_acc", 64'((c_out != '0) || (c_out16 != '0)), 64'd0);
    last24 = '0;
    last16 = '0;
    start_job(); finish_job(0, 1'b0, 1'b1);

    // Asynchronous reset mid-drain.
    fill(1); start_job(); feed(COLS, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("ovf16_before_rst", 64'(ovf16), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_state", 64'({in_ready, out_valid, busy, ovf, ovf16}), 64'd0);
    check("rst_mid_c_out", 64'((c_out != '0) || (c_out16 != '0)), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last24 = '0;
    last16 = '0;
    @(negedge clk);

    // Back-to-back: start from DONE without releasing the results.
    fill(2); start_job(); finish_job(2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("done_holds_valid", 64'(out_valid), 64'd1);
    fill(2); start_job(); finish_job(2, 1'b1, 1'b0);

    for (int k = 0; k < 5; k++) begin
      fill(($urandom_range(0, 3) == 0) ? 1 : 2);
      start_job();
      finish_job(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matvec_systolic.md
Name: matvec_systolic

Overview:
- Parametrised systolic matrix-vector multiplier: computes C = A x B, with A of size ROWS x COLS and B of length COLS; all values unsigned.
- Operands stream in one column per beat over a valid/ready handshake. Per-row skew registers and a forwarded enable tag handle bubbles, so the block does not need the whole matrix buffered before it starts.
- Sits between the memory-fetch front end and the result consumer; supersedes the fixed 8x8 multiplier.

Parameters:
- ROWS, 8, number of rows of A, which is also the number of processing elements (PEs).
- COLS, 8, vector length; beats per job.
- DW, 8, operand width for A and B elements.
- ACC_W, 24, accumulator and result width per row; legal range 2*DW to 48.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse: clear accumulators and begin a job. Honoured in IDLE or DONE only.
- clr  in  1  synchronous abort: return to IDLE and clear accumulators, pipeline tags and ovf.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- a_col  in  ROWS*DW  column j of A; A[i][j] at [i*DW +: DW].
- b_elem  in  DW  B[j].
- out_valid  out  1  results in c_out complete.
- out_ready  in  1  consumer accepts results.
- c_out  out  ROWS*ACC_W  C[i] at [i*ACC_W +: ACC_W].
- busy  out  1  high in LOAD or DRAIN.
- ovf  out  1  sticky: some accumulator exceeded 2^ACC_W-1 during the current job.

Behaviour:
- Reset values: state IDLE, in_ready=0, out_valid=0, busy=0, ovf=0, c_out=0, all PE enable tags=0.
- States and transitions:
  - IDLE: start -> LOAD; accumulators and ovf cleared at that edge.
  - LOAD: in_ready=1; a beat counter counts accepted beats. When the COLS-th beat is accepted -> DRAIN.
  - DRAIN: in_ready=0; a counter runs for ROWS cycles, then -> DONE.
  - DONE: out_valid=1. out_ready -> IDLE. start -> LOAD with a fresh clear (out_ready is ignored on that edge).
- Systolic timing: for a beat accepted at edge t:
  - row 0 accumulates A[0][j]*B[j] at edge t+1;
  - row i accumulates at edge t+1+i;
  - B and the enable tag move one PE per cycle; A for row i passes through an i-deep skew shift register.
- Bubbles: a cycle with in_valid=0 in LOAD injects enable=0, and every PE that sees enable=0 holds its accumulator. Results must therefore be independent of stall pattern.
- Latency: with the last beat accepted at edge T, out_valid rises after edge T+ROWS (row ROWS-1 finishes at T+ROWS).
- Arithmetic: each product is 2*DW bits, zero-extended to ACC_W. Without the optional feature, sums wrap modulo 2^ACC_W. ovf sets on any carry-out and holds until start, clr or reset.
- c_out is stable from DONE until the next start/clr; in IDLE it keeps the last results (out_valid=0).
- Precedence and boundary rules:
  - rst_n over clr over start.
  - start in LOAD or DRAIN is ignored.
  - in_valid in IDLE, DRAIN or DONE is ignored, since in_ready=0.
  - clr mid-job discards in-flight tags so that no later accumulate occurs.
  - Reset mid-job behaves identically to power-on reset.
  - COLS=1 is legal: one beat, then DRAIN.

Optional Feature:
- Macro MATVEC_SATURATE_EN.
- Defined: an accumulate that would exceed 2^ACC_W-1 clamps to 2^ACC_W-1 and stays there for the rest of the job; ovf sets as usual.
- Undefined: wrap-around as described above. ovf behaviour is identical in both builds.

Decomposition:
- Package matvec_pkg: state enum (IDLE, LOAD, DRAIN, DONE), function clog2-based counter-width helper, ACC_W legality check constant.
- Sub-module matvec_pe, one per row:
  - registers the A operand, enable tag and B forward;
  - MAC with sat/wrap and carry-out;
  - accumulator with synchronous clear.
- The top level holds the FSM, counters, skew shift registers and output packing.

Test Plan:
- Baseline: ROWS=COLS=8, A[i][j]=i+1, B[j]=1, in_valid held high -> C[i]=8*(i+1) (8,16,...,64); out_valid rises 8 cycles after the last beat; ovf=0.
- Maximum operands: all A and B = 255 -> every C[i]=520200 (0x7F008); ovf=0.
- Stalls: same data as baseline with in_valid toggled 1,0,1,0... -> identical C; exactly 8 beats accepted; in_ready=0 after the 8th.
- Overflow: ACC_W=16, all operands 255 -> wrap build C[i]=520200 mod 65536=61448; saturate build 65535; ovf=1 in both.
- Abort: clr after 4 beats, then start and a full baseline job -> baseline results. The same check with rst_n pulsed mid-DRAIN -> all outputs return to 0 immediately.
- Back-to-back: start asserted in DONE with out_ready=0 -> accumulators clear, the new job's results are correct, and the previous c_out is held until that start edge.
